// File: rtl/pipe_ctrl_chain_if.sv
// Bundle between the fetch side / hazard unit and the pipeline register chain:
// entry handshake, stage control requests, oldest-stage output and perf counters.
interface pipe_ctrl_chain_if #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic [WIDTH-1:0]  in_data;
   logic              in_ready;
   logic              freeze;
   logic              branch_taken;
   logic              hazard_stall;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic [STAGES-1:0] stage_valid;
   logic [CNT_W-1:0]  flush_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output in_valid, in_data, freeze, branch_taken, hazard_stall,
      input  in_ready, out_valid, out_data, stage_valid, flush_cnt, bubble_cnt
   );

   modport slave (
      input  in_valid, in_data, freeze, branch_taken, hazard_stall,
      output in_ready, out_valid, out_data, stage_valid, flush_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Parametrised pipeline register chain with central freeze, branch flush,
// load-use bubble insertion and saturating flush/bubble counters.
module pipe_ctrl_chain #(
   parameter int WIDTH       = 32,
   parameter int STAGES      = 4,
   parameter int FLUSH_DEPTH = 2,
   parameter int HAZ_STAGE   = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   pipe_ctrl_chain_if.slave bus
);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $fatal(1, "pipe_ctrl_chain: WIDTH must be at least 1");
      end
      if (STAGES < 2) begin : g_bad_stages
         $fatal(1, "pipe_ctrl_chain: STAGES must be at least 2");
      end
      if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES - 1) begin : g_bad_flush
         $fatal(1, "pipe_ctrl_chain: FLUSH_DEPTH must be in 1..STAGES-1");
      end
      if (HAZ_STAGE < 1 || HAZ_STAGE > STAGES - 1) begin : g_bad_haz
         $fatal(1, "pipe_ctrl_chain: HAZ_STAGE must be in 1..STAGES-1");
      end
      if (CNT_W < 1) begin : g_bad_cnt
         $fatal(1, "pipe_ctrl_chain: CNT_W must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      MODE_ADVANCE,
      MODE_FLUSH,
      MODE_STALL,
      MODE_HOLD
   } mode_t;

   mode_t                          mode;
   logic [STAGES-1:0]              stage_vld;
   logic [STAGES-1:0]              nxt_vld;
   logic [STAGES-1:0][WIDTH-1:0]   stage_dat;
   logic [STAGES-1:0][WIDTH-1:0]   nxt_dat;
   logic [CNT_W-1:0]               flush_cnt_q;
   logic [CNT_W-1:0]               bubble_cnt_q;

   // Fixed priority: a freeze masks everything, a flush masks a stall.
   always_comb begin
      mode = MODE_ADVANCE;
      if (bus.freeze) begin
         mode = MODE_HOLD;
      end else if (bus.branch_taken) begin
         mode = MODE_FLUSH;
      end else if (bus.hazard_stall) begin
         mode = MODE_STALL;
      end
   end

   assign bus.in_ready = !rst && (mode == MODE_ADVANCE || mode == MODE_FLUSH);

   always_comb begin
      nxt_vld = stage_vld;
      nxt_dat = stage_dat;
      case (mode)
         MODE_ADVANCE, MODE_FLUSH: begin
            nxt_vld[0] = bus.in_valid;
            nxt_dat[0] = bus.in_valid ? bus.in_data : '0;
            for (int i = 1; i < STAGES; i++) begin
               nxt_vld[i] = stage_vld[i-1];
               nxt_dat[i] = stage_dat[i-1];
            end
            // The branch itself has already moved to FLUSH_DEPTH; only wrong-path entries die.
            if (mode == MODE_FLUSH) begin
               for (int i = 0; i < FLUSH_DEPTH; i++) begin
                  nxt_vld[i] = 1'b0;
                  nxt_dat[i] = '0;
               end
            end
         end
         MODE_STALL: begin
            for (int i = HAZ_STAGE + 1; i < STAGES; i++) begin
               nxt_vld[i] = stage_vld[i-1];
               nxt_dat[i] = stage_dat[i-1];
            end
            nxt_vld[HAZ_STAGE] = 1'b0;
            nxt_dat[HAZ_STAGE] = '0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_vld    <= '0;
         stage_dat    <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stage_vld <= nxt_vld;
         stage_dat <= nxt_dat;
         if (mode == MODE_FLUSH && flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
         if (mode == MODE_STALL && bubble_cnt_q != {CNT_W{1'b1}}) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
         end
      end
   end

   assign bus.out_valid   = stage_vld[STAGES-1];
   assign bus.out_data    = stage_dat[STAGES-1];
   assign bus.stage_valid = stage_vld;
   assign bus.flush_cnt   = flush_cnt_q;
   assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
- Parametrised pipeline-register chain with centralised stall, freeze and flush control.
- Replaces the hand-instantiated per-stage registers of the ARM core and their hard-tied freeze/flush/branch signals.
- Each stage carries a WIDTH-bit payload plus a valid bit.
- The chain implements global freeze, branch flush of the youngest stages, load-use bubble insertion and saturating performance counters.

Parameters:
WIDTH, 32, payload bits per stage (packed PC, instruction and control fields)
STAGES, 4, number of register stages; index 0 is youngest (IF/ID), STAGES-1 is oldest (MEM/WB)
FLUSH_DEPTH, 2, number of youngest stages killed by branch_taken; legal range 1..STAGES-1
HAZ_STAGE, 1, stage that receives a bubble on hazard_stall; legal range 1..STAGES-1
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch-side entry valid
in_data  in  WIDTH  fetch-side payload
in_ready  out  1  entry is consumed this cycle
freeze  in  1  global hold of every stage (memory wait)
branch_taken  in  1  flush request from the execute stage
hazard_stall  in  1  load-use stall from hazard unit
out_valid  out  1  valid of stage STAGES-1
out_data  out  WIDTH  payload of stage STAGES-1
stage_valid  out  STAGES  valid bit of every stage, bit i = stage i
flush_cnt  out  CNT_W  cycles in which a flush was applied
bubble_cnt  out  CNT_W  bubbles inserted by hazard_stall

Behaviour:
Reset:
- rst asserted at any time, including mid-stall or mid-flush, immediately clears all valids, payloads and both counters to 0.
- While rst is high, in_ready=0.
- First capture occurs on the first rising edge after rst deasserts.

Per-cycle priority is freeze > branch_taken > hazard_stall > advance.

ADVANCE (no control input asserted):
- stage0 <= {in_valid, in_data}.
- stage i <= stage i-1 for i >= 1.
- in_ready=1.
- Bubbles (valid=0) shift like real entries; the payload is don't-care but cleared to 0.

FREEZE:
- All stages and counters hold.
- in_ready=0.
- branch_taken and hazard_stall are ignored that cycle; the requester holds them until freeze drops.

FLUSH (branch_taken=1, freeze=0):
- Stages 0..FLUSH_DEPTH-1 load bubbles.
- Stages >= FLUSH_DEPTH shift normally: stage FLUSH_DEPTH receives the old stage FLUSH_DEPTH-1, which holds the branch.
- in_ready=1; the input is consumed and dropped as wrong-path.
- hazard_stall is ignored.
- flush_cnt increments.

STALL (hazard_stall=1, freeze=0, branch_taken=0):
- Stages 0..HAZ_STAGE-1 hold.
- Stage HAZ_STAGE loads a bubble.
- Stages > HAZ_STAGE shift.
- in_ready=0.
- bubble_cnt increments.

Outputs and counters:
- Latency from capture to out_valid is STAGES cycles with no stalls; each freeze or stall cycle adds 1.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Outputs are driven directly from registers; there is no combinational path from in_data to out_data.
- in_ready is combinational from freeze, branch_taken, hazard_stall and rst.
- Illegal parameters (out of range) must fail elaboration.

Test Plan:
Defaults are used (STAGES=4, FLUSH_DEPTH=2, HAZ_STAGE=1) unless noted.
1. Reset then stream:
   - Stimulus: in_data=0x10,0x11,0x12,... with in_valid=1.
   - Required: out_valid rises on the 4th edge with out_data=0x10, then one entry per cycle; stage_valid=4'b1111.
2. Freeze:
   - Stimulus: chain full of 0xA0..0xA3, freeze held 3 cycles.
   - Required: stage contents and counters unchanged, in_ready=0; the stream resumes with no loss.
3. Flush:
   - Stimulus: stage1=0xB1 (branch), stage0=0xB0, branch_taken pulsed 1 cycle.
   - Required: next cycle stage_valid[1:0]=00 and stage2=0xB1; flush_cnt=1; 0xB0 and the concurrent input never reach out_data.
4. Load-use stall:
   - Stimulus: stage0=0xC0, hazard_stall 1 cycle.
   - Required: stage0 still 0xC0, stage1 valid=0, in_ready=0, bubble_cnt=1; the input on that cycle is accepted the following cycle.
5. Simultaneous events:
   - Stimulus A: branch_taken and hazard_stall together. Required: flush result only, bubble_cnt unchanged.
   - Stimulus B: freeze, branch_taken and hazard_stall together. Required: full hold, no counter change.
6. Async reset and saturation:
   - Stimulus A: rst pulsed mid-stall, between clock edges. Required: all stage_valid and counters go to 0 immediately.
   - Stimulus B: CNT_W=4 with 20 flushes. Required: flush_cnt holds at 15.
